// File: rtl/core_mem_pkg.sv
// Shared types for the fetch/data memory arbiter.
// FSM states, port ownership and the NOP returned when idle.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/arb_prio.sv
// Winner select between fetch and data requests.
// Data wins unless fetch has been starved long enough.
module arb_prio
    import core_mem_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_req_mem,
    input  logic       i_starve_hit,
    output logic       o_valid,
    output arb_owner_e o_owner
);

    logic w_d_win;

    assign w_d_win = i_req_mem && !(i_starve_hit && i_if_req);
    assign o_valid = i_req_mem || i_if_req;
    assign o_owner = w_d_win ? OWN_D : OWN_IF;

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction outstanding; data priority with fetch starvation guard.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int IF_STARVE_MAX = 4,
    parameter int GNT_TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] pc_o,
    output logic [31:0]     inst,
    output logic            inst_stall,
    output logic            inst_access_fault,
    input  logic            req_mem,
    input  logic            wmem_o,
    input  logic [3:0]      wmask,
    input  logic [XLEN-1:0] addr_o,
    input  logic [XLEN-1:0] data_o,
    output logic [XLEN-1:0] data_i,
    output logic            data_stall,
    output logic            data_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err,
    output logic            busy
);

    localparam logic [15:0] L_TMO = 16'(GNT_TIMEOUT);
    localparam logic [7:0]  L_STV = 8'(IF_STARVE_MAX);

    arb_state_e      r_state;
    arb_owner_e      r_owner;
    logic            r_stale;
    logic [15:0]     r_gcnt;
    logic [7:0]      r_scnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [3:0]      r_mem_wmask;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;

    logic       w_starve_hit;
    logic       w_win_v;
    arb_owner_e w_win;
    logic       w_own_req;
    logic       w_gnt;
    logic       w_tmo;
    logic       w_resp;
    logic       w_done;
    logic       w_done_if;
    logic       w_done_d;

    assign w_starve_hit = (IF_STARVE_MAX != 0) && (r_scnt >= L_STV);

    arb_prio u_prio (
        .i_if_req     (if_req),
        .i_req_mem    (req_mem),
        .i_starve_hit (w_starve_hit),
        .o_valid      (w_win_v),
        .o_owner      (w_win)
    );

    assign w_own_req = (r_owner == OWN_IF) ? if_req : req_mem;
    assign w_gnt     = (r_state == ISSUE) && mem_gnt;
    // A grant arriving in the expiry cycle takes precedence over the abort
    assign w_tmo     = (r_state == ISSUE) && !mem_gnt && (GNT_TIMEOUT != 0)
                       && (r_gcnt == L_TMO - 16'd1);
    assign w_resp    = (r_state == WAIT) && mem_rvalid;
    assign w_done    = (w_resp || w_tmo) && !r_stale;
    assign w_done_if = w_done && (r_owner == OWN_IF);
    assign w_done_d  = w_done && (r_owner == OWN_D);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_stale     <= 1'b0;
            r_gcnt      <= '0;
            r_scnt      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wmask <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_v) begin
                        r_state   <= ISSUE;
                        r_owner   <= w_win;
                        r_stale   <= 1'b0;
                        r_gcnt    <= '0;
                        r_mem_req <= 1'b1;
                        if (w_win == OWN_D) begin
                            r_mem_addr  <= addr_o;
                            r_mem_we    <= wmem_o;
                            r_mem_wmask <= wmask;
                            r_mem_wdata <= data_o;
                        end else begin
                            r_mem_addr  <= pc_o;
                            r_mem_we    <= 1'b0;
                            r_mem_wmask <= '0;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (!w_own_req) r_stale <= 1'b1;
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end else if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_stale   <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 16'd1;
                    end
                end
                WAIT: begin
                    if (!w_own_req) r_stale <= 1'b1;
                    if (mem_rvalid) begin
                        r_stale <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Consecutive data grants seen while fetch keeps waiting
            if (!if_req) begin
                r_scnt <= '0;
            end else if (w_gnt && r_owner == OWN_IF) begin
                r_scnt <= '0;
            end else if (w_gnt && r_scnt != 8'hFF) begin
                r_scnt <= r_scnt + 8'd1;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_wmask = r_mem_wmask;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

    assign inst_stall        = if_req && !w_done_if;
    assign inst              = w_done_if ? (w_tmo ? 32'd0 : mem_rdata[31:0])
                                         : NOP_INST;
    assign inst_access_fault = w_done_if && (w_tmo || mem_err);

    assign data_stall = req_mem && !w_done_d;
    assign data_i     = (w_done_d && !w_tmo && !r_mem_we) ? mem_rdata : '0;
    assign data_err   = w_done_d && (w_tmo || mem_err);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus a randomized
// core/memory run checked against a word-level reference memory.
module tb_core_mem_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'h0000_03FC;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] pc_o;
    logic [31:0] inst;
    logic        inst_stall;
    logic        inst_access_fault;
    logic        req_mem;
    logic        wmem_o;
    logic [3:0]  wmask;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        data_stall;
    logic        data_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        busy;

    core_mem_arbiter #(
        .XLEN          (32),
        .IF_STARVE_MAX (4),
        .GNT_TIMEOUT   (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_req            (if_req),
        .pc_o              (pc_o),
        .inst              (inst),
        .inst_stall        (inst_stall),
        .inst_access_fault (inst_access_fault),
        .req_mem           (req_mem),
        .wmem_o            (wmem_o),
        .wmask             (wmask),
        .addr_o            (addr_o),
        .data_o            (data_o),
        .data_i            (data_i),
        .data_stall        (data_stall),
        .data_err          (data_err),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_wmask         (mem_wmask),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .mem_err           (mem_err),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rmem    [256];
    logic [31:0] ref_mem [256];
    logic [31:0] glog    [$];
    int gmode = 0;
    int lat   = 1;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Byte a..a+3 of the initial image holds its own low address byte
    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0] & 8'hFC;
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_i(input int max);
        int n = 0;
        do begin
            nxt();
            n++;
        end while (inst_stall && n < max);
        chk("wait_i", 32'(inst_stall), 0);
    endtask

    task automatic wait_d(input int max);
        int n = 0;
        do begin
            nxt();
            n++;
        end while (data_stall && n < max);
        chk("wait_d", 32'(data_stall), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 20) begin
            nxt();
            n++;
        end
        chk("drain", 32'(busy), 0);
    endtask

    // Memory responder: grant policy by gmode, response after lat cycles
    int          rv_cnt = 0;
    int          g_wait = 0;
    bit          g_armed = 0;
    bit          p_pend = 0;
    int          streak = 0;
    logic [31:0] rv_data;
    logic        rv_err;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [31:0] p_ctl;

    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_err    = 1'b0;
            if (!reset) begin
                rv_cnt  = 0;
                g_armed = 0;
                p_pend  = 0;
                streak  = 0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        mem_err    = rv_err;
                    end
                end
                if (p_pend && mem_req) begin
                    chk("hold_a", mem_addr, p_addr);
                    chk("hold_d", mem_wdata, p_wdata);
                    chk("hold_c", {27'd0, mem_we, mem_wmask}, p_ctl);
                end
                p_pend = 0;
                if (!if_req) streak = 0;
                if (mem_req) begin
                    chk("one_out", rv_cnt, 0);
                    if (!g_armed) begin
                        g_armed = 1;
                        g_wait  = (gmode == 1) ? $urandom_range(0, 2) : 0;
                    end
                    if (gmode != 2 && g_wait == 0) begin
                        mem_gnt = 1'b1;
                        g_armed = 0;
                        glog.push_back(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_we && mem_wmask[b])
                                rmem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        rv_data = mem_we ? 32'd0 : rmem[mem_addr[9:2]];
                        rv_err  = (mem_addr == BAD);
                        rv_cnt  = lat;
                        if (mem_addr >= 32'h100 && mem_addr < 32'h200) begin
                            streak = 0;
                        end else if (if_req) begin
                            streak++;
                            chk("starve", 32'(streak <= 4), 1);
                        end
                    end else begin
                        if (g_wait > 0) g_wait--;
                        p_pend  = 1;
                        p_addr  = mem_addr;
                        p_wdata = mem_wdata;
                        p_ctl   = {27'd0, mem_we, mem_wmask};
                    end
                end else begin
                    g_armed = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit          f_act = 0;
    bit          d_act = 0;
    bit          d_we  = 0;
    logic [31:0] f_pc  = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_data = '0;
    logic [3:0]  d_mask = '0;
    logic [31:0] exp_a;
    int          run;
    int          r;

    initial begin
        reset   = 1'b0;
        if_req  = 1'b0;
        pc_o    = '0;
        req_mem = 1'b0;
        wmem_o  = 1'b0;
        wmask   = '0;
        addr_o  = '0;
        data_o  = '0;
        for (int i = 0; i < 256; i++) begin
            rmem[i]    = init_word(32'(i * 4));
            ref_mem[i] = init_word(32'(i * 4));
        end
        repeat (3) nxt();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_inst", inst, NOP);
        chk("rst_di", data_i, 0);
        reset = 1'b1;
        nxt();

        // Zero-wait fetch latency
        if_req = 1'b1;
        pc_o   = 32'h100;
        nxt();
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_stall", 32'(inst_stall), 1);
        nxt();
        chk("t1_done", 32'(inst_stall), 0);
        chk("t1_inst", inst, init_word(32'h100));
        chk("t1_flt", 32'(inst_access_fault), 0);
        if_req = 1'b0;
        nxt();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_nop", inst, NOP);

        // Fetch and load together: data first
        if_req  = 1'b1;
        pc_o    = 32'h0;
        req_mem = 1'b1;
        addr_o  = 32'h20;
        nxt();
        chk("t2_first", mem_addr, 32'h20);
        nxt();
        chk("t2_dstall", 32'(data_stall), 0);
        chk("t2_data", data_i, 32'h2322_2120);
        chk("t2_istall", 32'(inst_stall), 1);
        req_mem = 1'b0;
        wait_i(10);
        chk("t2_inst", inst, init_word(32'h0));
        if_req = 1'b0;
        nxt();

        // Continuous contention: 4 data grants then 1 fetch grant
        glog.delete();
        if_req  = 1'b1;
        pc_o    = 32'h180;
        req_mem = 1'b1;
        addr_o  = 32'h40;
        repeat (40) nxt();
        if_req  = 1'b0;
        req_mem = 1'b0;
        drain();
        run = 0;
        for (int k = 0; k < 10; k++) begin
            exp_a = (run == 4) ? 32'h180 : 32'h40;
            run   = (run == 4) ? 0 : run + 1;
            chk("t3_gnt", glog[k], exp_a);
        end

        // Byte store then read-back
        req_mem = 1'b1;
        wmem_o  = 1'b1;
        wmask   = 4'b0001;
        data_o  = 32'hAB;
        addr_o  = 32'h40;
        nxt();
        chk("t4_we", 32'(mem_we), 1);
        chk("t4_mask", 32'(mem_wmask), 1);
        chk("t4_wd", mem_wdata, 32'hAB);
        nxt();
        chk("t4_done", 32'(data_stall), 0);
        chk("t4_err", 32'(data_err), 0);
        ref_mem[16][7:0] = 8'hAB;
        req_mem = 1'b0;
        wmem_o  = 1'b0;
        wmask   = '0;
        nxt();
        req_mem = 1'b1;
        wait_d(10);
        chk("t4_rd", data_i, 32'h4342_41AB);
        req_mem = 1'b0;
        nxt();

        // Grant never comes: error on the 8th ISSUE cycle
        gmode   = 2;
        req_mem = 1'b1;
        addr_o  = 32'h44;
        for (int c = 1; c <= 8; c++) begin
            nxt();
            chk("t5_req", 32'(mem_req), 1);
            chk("t5_err", 32'(data_err), 32'(c == 8));
            chk("t5_stall", 32'(data_stall), 32'(c != 8));
        end
        chk("t5_di", data_i, 0);
        req_mem = 1'b0;
        nxt();
        chk("t5_drop", 32'(mem_req), 0);
        chk("t5_idle", 32'(busy), 0);
        gmode = 0;

        // Load abandoned in WAIT; its response must be absorbed
        lat     = 3;
        req_mem = 1'b1;
        addr_o  = 32'h48;
        nxt();
        nxt();
        chk("t6_wait", 32'(data_stall), 1);
        req_mem = 1'b0;
        nxt();
        req_mem = 1'b1;
        addr_o  = 32'h4C;
        lat     = 1;
        nxt();
        chk("t6_absorb", 32'(data_stall), 1);
        chk("t6_di0", data_i, 0);
        wait_d(10);
        chk("t6_data", data_i, 32'h4F4E_4D4C);
        req_mem = 1'b0;
        nxt();

        // Reset while a store is in WAIT
        lat     = 3;
        req_mem = 1'b1;
        wmem_o  = 1'b1;
        wmask   = 4'hF;
        data_o  = 32'hDEAD_BEEF;
        addr_o  = 32'h50;
        nxt();
        nxt();
        chk("t7_busy", 32'(busy), 1);
        // Memory already accepted the write before the reset
        ref_mem[20] = 32'hDEAD_BEEF;
        reset = 1'b0;
        nxt();
        chk("t7_idle", 32'(busy), 0);
        chk("t7_req", 32'(mem_req), 0);
        chk("t7_we", 32'(mem_we), 0);
        chk("t7_mask", 32'(mem_wmask), 0);
        chk("t7_addr", mem_addr, 0);
        chk("t7_wd", mem_wdata, 0);
        reset   = 1'b1;
        req_mem = 1'b0;
        wmem_o  = 1'b0;
        wmask   = '0;
        lat     = 1;
        nxt();

        // Randomized core traffic against the reference memory
        gmode = 1;
        for (int c = 0; c < 600; c++) begin
            nxt();
            if (f_act && !inst_stall) begin
                chk("r_inst", inst, init_word(f_pc));
                chk("r_iflt", 32'(inst_access_fault), 0);
                f_act = 0;
            end
            if (d_act && !data_stall) begin
                if (d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (d_mask[b])
                            ref_mem[d_addr[9:2]][8*b +: 8] = d_data[8*b +: 8];
                    chk("r_serr", 32'(data_err), 0);
                end else if (d_addr == BAD) begin
                    chk("r_derr", 32'(data_err), 1);
                end else begin
                    chk("r_load", data_i, ref_mem[d_addr[9:2]]);
                    chk("r_lerr", 32'(data_err), 0);
                end
                d_act = 0;
            end
            lat = $urandom_range(1, 3);
            if (!f_act && $urandom_range(0, 3) != 0) begin
                f_act = 1;
                f_pc  = 32'h100 + 32'(4 * $urandom_range(0, 63));
            end
            if (!d_act && $urandom_range(0, 2) != 0) begin
                d_act  = 1;
                r      = $urandom_range(0, 9);
                d_we   = (r < 4);
                d_addr = (r == 9) ? BAD : 32'(4 * $urandom_range(0, 63));
                d_mask = 4'($urandom_range(1, 15));
                d_data = $urandom;
            end
            if_req  = f_act;
            pc_o    = f_pc;
            req_mem = d_act;
            wmem_o  = d_we;
            addr_o  = d_addr;
            wmask   = d_we ? d_mask : 4'd0;
            data_o  = d_data;
        end
        if_req  = 1'b0;
        req_mem = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the RV32I core's instruction-fetch port and its load/store port.
- Sits between the core and the memory model or bus. It generates inst_stall, data_stall, inst_access_fault and data_err for the core.
- Data requests have priority over fetch, with a starvation guard for fetch and a grant timeout. At most one memory transaction is outstanding at a time.

Parameters:
- XLEN, 32, address and data width.
- IF_STARVE_MAX, 4, number of consecutive data grants while fetch is waiting before fetch is forced to win; 0 disables the guard.
- GNT_TIMEOUT, 255, number of cycles mem_req may wait for mem_gnt before the transaction is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request (core drives it high while fetching).
- pc_o  in  XLEN  fetch byte address.
- inst  out  32  fetched instruction.
- inst_stall  out  1  fetch not complete.
- inst_access_fault  out  1  fetch error.
- req_mem  in  1  data request.
- wmem_o  in  1  1 = store, 0 = load.
- wmask  in  4  store byte enables.
- addr_o  in  XLEN  data byte address.
- data_o  in  XLEN  store data.
- data_i  out  XLEN  load data.
- data_stall  out  1  data access not complete.
- data_err  out  1  data error.
- mem_req  out  1  memory request, held until mem_gnt.
- mem_we  out  1  memory write enable.
- mem_wmask  out  4  memory byte enables.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response valid; returned for both reads and writes.
- mem_rdata  in  XLEN  response data.
- mem_err  in  1  response error, qualified by mem_rvalid.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset = 0 at a clk edge):
  - state = IDLE; owner, stale and all counters = 0.
  - mem_req, mem_we, mem_wmask, mem_addr, mem_wdata = 0.
  - Any outstanding transaction is dropped. The memory must share this reset, so no stale mem_rvalid can arrive afterwards.
- States: IDLE, ISSUE, WAIT. A register owner records which port won (IF or D).
- IDLE:
  - If req_mem is high and fetch is not starving, data wins; otherwise, if if_req is high, fetch wins.
  - The winner's address, we, wmask and wdata are registered into mem_*. A fetch issues we = 0, wmask = 0.
  - mem_req is driven high next cycle and state moves to ISSUE.
- ISSUE:
  - mem_req and all mem_* are held stable until mem_gnt = 1, then mem_req drops and state moves to WAIT.
  - A grant-wait counter increments each cycle in ISSUE. If it reaches GNT_TIMEOUT, mem_req drops, the owner port completes with an error that cycle, and state returns to IDLE.
- WAIT: on mem_rvalid, the owner completes and state returns to IDLE. There is no back-to-back issue in the same cycle.
- Completion cycle, combinational:
  - The owner's stall is 0 for exactly one cycle.
  - For fetch, inst = mem_rdata and inst_access_fault = mem_err.
  - For data, data_i = mem_rdata (loads) and data_err = mem_err.
  - On a timeout completion, the fault/err output is 1 and the data output is 0.
- Outside a completion cycle:
  - inst_stall = if_req and data_stall = req_mem.
  - inst = 32'h00000013 (NOP) and data_i = 0.
  - Fault and error outputs are 0.
- Minimum latency: request seen in cycle 0, mem_req in cycle 1, zero-wait grant in cycle 1, rvalid in cycle 2, stall low in cycle 2.
- Request stability: the core holds its address and data stable while stalled. The arbiter samples them only in IDLE.
- Flush and abandonment:
  - If the owner's request deasserts while in ISSUE or WAIT, stale is set.
  - The response for a stale transaction is absorbed without signalling completion.
  - A new request from that port stalls until the stale transaction retires.
- Starvation guard:
  - The counter increments on each data grant while if_req is high.
  - It clears on a fetch grant or when if_req is low.
  - At IF_STARVE_MAX, the next arbitration in IDLE goes to fetch.
- Simultaneous mem_gnt and timeout expiry: mem_gnt wins.
- mem_rvalid in IDLE or ISSUE is ignored.

Decomposition:
- Package core_mem_pkg holds:
  - typedef arb_state_e {IDLE, ISSUE, WAIT};
  - typedef arb_owner_e {OWN_IF, OWN_D};
  - localparam NOP_INST = 32'h13.
- Sub-module arb_prio: combinational winner select from if_req, req_mem and starve_hit.
- Counters and FSM stay in the top module.

Test Plan:
- Zero-wait memory (gnt immediate, rvalid the next cycle) with a fetch at pc_o 0x100: mem_addr = 0x100 in cycle 1, inst = mem_rdata and inst_stall = 0 in cycle 2.
- Fetch and load requested together (pc_o 0x0, addr_o 0x20): data is served first and data_i = 0x23222120; fetch then completes with inst_stall high until then.
- Data requests held continuously with IF_STARVE_MAX = 4 and if_req high: exactly 4 data grants, then 1 fetch grant, repeating.
- Store sb (wmask 4'b0001, data_o 0xAB, addr_o 0x40): mem_we = 1, mem_wmask = 1, mem_wdata = 0xAB; data_stall drops on the write ack.
- mem_gnt tied low with GNT_TIMEOUT = 8: after 8 ISSUE cycles, data_err = 1 for one cycle, mem_req drops, state returns to IDLE.
- Two abandonment and reset cases:
  - req_mem drops during WAIT, then a new load arrives: the old rvalid is absorbed and the new load completes on its own rvalid.
  - reset = 0 asserted during WAIT: outputs return to their reset values on the next edge.
